// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with packet locking and a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned IDW          = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              locked,
  output logic              err_timeout
);

  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } arbState_t;

  arbState_t       state;
  logic [IDW-1:0]  rrPtr;
  logic [CNTW-1:0] busyCnt;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pickOneHot;
  logic            found;
  logic [IDW-1:0]  pickIdx;
  logic [IDW-1:0]  pickNext;
  logic [IDW-1:0]  grantNext;
  logic [7:0]      pickData;
  logic            pickLast;

  // While a packet is open only its owner may be served.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & (~locked | (32'(grant_id) == i));
    end
  end

  // First eligible requester at or after rrPtr, wrapping at NREQ.
  always_comb begin
    found      = 1'b0;
    pickIdx    = '0;
    pickNext   = '0;
    pickData   = '0;
    pickLast   = 1'b0;
    pickOneHot = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && eligible[i] && (i == ((32'(rrPtr) + off) % NREQ))) begin
          found         = 1'b1;
          pickIdx       = IDW'(i);
          pickNext      = IDW'((i + 1) % NREQ);
          pickData      = req_data[8*i +: 8];
          pickLast      = req_last[i];
          pickOneHot[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grantNext = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(grant_id) == i) grantNext = IDW'((i + 1) % NREQ);
    end
  end

  // Reset only forgets an in-flight frame; the serializer finishes it on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rrPtr       <= '0;
      busyCnt     <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !tx_busy) begin
            tx_data   <= pickData;
            grant_id  <= pickIdx;
            tx_start  <= 1'b1;
            req_ready <= pickOneHot;
            busyCnt   <= '0;
            state     <= WAIT_BUSY;
            if (pickLast) begin
              locked <= 1'b0;
              rrPtr  <= pickNext;
            end else begin
              locked <= 1'b1;
            end
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            busyCnt <= '0;
            state   <= WAIT_DONE;
          end else if (busyCnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            rrPtr       <= grantNext;
            busyCnt     <= '0;
            state       <= IDLE;
          end else begin
            busyCnt <= busyCnt + CNTW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: capture-order tables plus hand sequences
// for latency, busy gating, timeout, reset mid-packet and a 3-requester wrap.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned IDW          = 2;
  localparam int unsigned BUSY_TIMEOUT = 15;
  localparam int unsigned FRAME_LEN    = 20;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              locked;
  logic              err_timeout;

  logic [2:0]  v3, l3, rdy3;
  logic [23:0] d3;
  logic        start3, busy3, locked3, err3;
  logic [7:0]  data3;
  logic [1:0]  gid3;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.NREQ(3), .IDW(2), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3),
    .req_last(l3), .req_ready(rdy3), .tx_start(start3),
    .tx_data(data3), .tx_busy(busy3), .grant_id(gid3),
    .locked(locked3), .err_timeout(err3)
  );

  typedef struct {
    int         scen;
    int         req;
    logic [7:0] data;
    logic       last;
    int         expOrder;
    logic       expLocked;
  } vec_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
  } pend_t;

  typedef struct {
    int         gid;
    logic [7:0] data;
    logic       locked;
    logic [3:0] ready;
  } cap_t;

  vec_t  vecs[$];
  pend_t pend[$];
  cap_t  capLog[$];

  int nCmp, nFail;
  int txMode;
  int dlyCnt, busyLeft, busy3Cnt;
  bit drvEn;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input int s, input int r, input logic [7:0] d, input logic l,
                        input int o, input logic lk);
    vec_t v;
    v.scen = s; v.req = r; v.data = d; v.last = l; v.expOrder = o; v.expLocked = lk;
    vecs.push_back(v);
  endtask

  task automatic addPend(input int r, input logic [7:0] d, input logic l);
    pend_t p;
    p.req = r; p.data = d; p.last = l;
    pend.push_back(p);
  endtask

  // Requesters: each presents its oldest pending byte until it sees req_ready.
  task automatic driveReqs();
    logic [NREQ-1:0]   v;
    logic [8*NREQ-1:0] d;
    logic [NREQ-1:0]   l;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].req == i) begin
            pend.delete(k);
            break;
          end
        end
      end
    end
    v = '0; d = '0; l = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].req == i) begin
          v[i]        = 1'b1;
          d[8*i +: 8] = pend[k].data;
          l[i]        = pend[k].last;
          break;
        end
      end
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  // One clock: sample outputs at the falling edge, then update the models.
  task automatic tick();
    cap_t c;
    @(negedge clk);
    check("ready_onehot", 32'($countones(req_ready)), 32'(tx_start));
    if (tx_start) begin
      c.gid = int'(grant_id); c.data = tx_data; c.locked = locked; c.ready = req_ready;
      capLog.push_back(c);
    end
    if (txMode == 0) begin
      if (dlyCnt > 0) begin
        dlyCnt--;
        if (dlyCnt == 0) begin
          tx_busy  = 1'b1;
          busyLeft = FRAME_LEN;
        end
      end else if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) tx_busy = 1'b0;
      end
      if (tx_start) dlyCnt = 2;
    end else if (txMode == 1) begin
      tx_busy = 1'b0;
    end
    if (drvEn) driveReqs();
    if (busy3Cnt > 0) busy3Cnt--;
    if (start3) busy3Cnt = 3;
    busy3 = (busy3Cnt != 0);
  endtask

  task automatic doReset();
    drvEn = 1'b0;
    pend.delete();
    req_valid = '0; req_data = '0; req_last = '0;
    v3 = '0; d3 = '0; l3 = '0;
    txMode = 0; tx_busy = 1'b0; dlyCnt = 0; busyLeft = 0;
    busy3 = 1'b0; busy3Cnt = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    capLog.delete();
  endtask

  task automatic runScen(input int s);
    int n, budget, o;
    doReset();
    n = 0;
    foreach (vecs[k]) begin
      if (vecs[k].scen == s) begin
        addPend(vecs[k].req, vecs[k].data, vecs[k].last);
        n++;
      end
    end
    drvEn  = 1'b1;
    budget = 0;
    while (pend.size() != 0 && budget < 600) begin
      tick();
      budget++;
    end
    check($sformatf("s%0d_drained", s), 32'(pend.size()), 32'(0));
    repeat (30) tick();
    check($sformatf("s%0d_count", s), 32'(capLog.size()), 32'(n));
    foreach (vecs[k]) begin
      if (vecs[k].scen == s) begin
        o = vecs[k].expOrder;
        if (o < capLog.size()) begin
          check($sformatf("s%0d_grant%0d", s, o), 32'(capLog[o].gid), 32'(vecs[k].req));
          check($sformatf("s%0d_data%0d", s, o), 32'(capLog[o].data), 32'(vecs[k].data));
          check($sformatf("s%0d_locked%0d", s, o), 32'(capLog[o].locked), 32'(vecs[k].expLocked));
          check($sformatf("s%0d_ready%0d", s, o), 32'(capLog[o].ready), 32'(1) << vecs[k].req);
        end
      end
    end
    drvEn = 1'b0;
  endtask

  initial begin
    int b, n;
    nCmp = 0; nFail = 0;
    rst = 1'b1; drvEn = 1'b0; txMode = 0;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    v3 = '0; d3 = '0; l3 = '0; busy3 = 1'b0;
    dlyCnt = 0; busyLeft = 0; busy3Cnt = 0;

    // scen, req, data, last, capture order, locked after capture
    addVec(0, 2, 8'h41, 1'b1, 0, 1'b0);
    addVec(1, 0, 8'h10, 1'b1, 0, 1'b0);
    addVec(1, 1, 8'h11, 1'b1, 1, 1'b0);
    addVec(1, 2, 8'h12, 1'b1, 2, 1'b0);
    addVec(1, 3, 8'h13, 1'b1, 3, 1'b0);
    addVec(1, 0, 8'h14, 1'b1, 4, 1'b0);
    addVec(2, 0, 8'h01, 1'b1, 0, 1'b0);
    addVec(2, 1, 8'hA0, 1'b0, 1, 1'b1);
    addVec(2, 1, 8'hA1, 1'b0, 2, 1'b1);
    addVec(2, 1, 8'hA2, 1'b1, 3, 1'b0);
    addVec(2, 0, 8'hB0, 1'b1, 5, 1'b0);
    addVec(2, 3, 8'hC0, 1'b1, 4, 1'b0);

    // Idle after reset: everything stays zero.
    doReset();
    repeat (10) begin
      tick();
      check("idle_outputs", 32'({tx_start, req_ready, tx_data, grant_id, locked, err_timeout}), 32'(0));
      check("idle3_outputs", 32'({start3, rdy3, data3, gid3, locked3, err3}), 32'(0));
    end

    // Single requester: start and ready appear one cycle after valid is sampled.
    doReset();
    req_valid = 4'b0100; req_data = 32'h0041_0000; req_last = 4'b0100;
    tick();
    check("lat_start", 32'(tx_start), 32'(1));
    check("lat_ready", 32'(req_ready), 32'(4'b0100));
    check("lat_data", 32'(tx_data), 32'(8'h41));
    check("lat_grant", 32'(grant_id), 32'(2));
    req_valid = '0;
    tick();
    check("lat_start_drop", 32'({tx_start, req_ready}), 32'(0));
    check("lat_data_held", 32'(tx_data), 32'(8'h41));

    runScen(0);
    runScen(1);
    runScen(2);

    // Busy transmitter in IDLE blocks capture until it falls.
    doReset();
    txMode = 2; tx_busy = 1'b1;
    req_valid = 4'b0001; req_data = 32'h0000_00C3; req_last = 4'b0001;
    repeat (5) begin
      tick();
      check("no_start_while_busy", 32'(tx_start), 32'(0));
    end
    tx_busy = 1'b0;
    tick();
    check("start_after_busy", 32'(tx_start), 32'(1));
    check("start_after_busy_data", 32'(tx_data), 32'(8'hC3));
    req_valid = '0;

    // Transmitter never answers: timeout releases the lock and serves the next one.
    doReset();
    txMode = 1;
    addPend(0, 8'h55, 1'b0);
    addPend(1, 8'h66, 1'b1);
    drvEn = 1'b1;
    b = 0;
    while (!tx_start && b < 20) begin
      tick();
      b++;
    end
    check("to_first_start", 32'(tx_start), 32'(1));
    check("to_first_grant", 32'(grant_id), 32'(0));
    check("to_first_locked", 32'(locked), 32'(1));
    n = 0;
    while (!err_timeout && n < 40) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'(BUSY_TIMEOUT));
    check("to_unlock", 32'(locked), 32'(0));
    tick();
    check("to_pulse_len", 32'(err_timeout), 32'(0));
    check("to_next_start", 32'(tx_start), 32'(1));
    check("to_next_grant", 32'(grant_id), 32'(1));
    check("to_next_data", 32'(tx_data), 32'(8'h66));
    drvEn = 1'b0;

    // Reset while locked mid-packet in WAIT_DONE clears the lock and the pointer.
    doReset();
    addPend(1, 8'h80, 1'b1);
    addPend(2, 8'h90, 1'b0);
    addPend(2, 8'h91, 1'b1);
    drvEn = 1'b1;
    b = 0;
    while (!(capLog.size() == 2 && tx_busy) && b < 200) begin
      tick();
      b++;
    end
    check("rst_reach_second", 32'(capLog.size()), 32'(2));
    tick();
    check("rst_pre_locked", 32'(locked), 32'(1));
    addPend(0, 8'hB0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", 32'({tx_start, req_ready, tx_data, grant_id, locked, err_timeout}), 32'(0));
    b = 0;
    while (pend.size() != 0 && b < 200) begin
      tick();
      b++;
    end
    check("rst_drained", 32'(capLog.size()), 32'(4));
    if (capLog.size() == 4) begin
      check("rst_after_grant", 32'(capLog[2].gid), 32'(0));
      check("rst_after_data", 32'(capLog[2].data), 32'(8'hB0));
      check("rst_resume_grant", 32'(capLog[3].gid), 32'(2));
      check("rst_resume_data", 32'(capLog[3].data), 32'(8'h91));
    end
    drvEn = 1'b0;

    // Three requesters: pointer wraps from 2 back to 0.
    doReset();
    v3 = 3'b100; d3 = 24'h22_0000; l3 = 3'b111;
    b = 0;
    while (!start3 && b < 20) begin
      tick();
      b++;
    end
    check("n3_grant_a", 32'(gid3), 32'(2));
    check("n3_data_a", 32'(data3), 32'(8'h22));
    check("n3_ready_a", 32'(rdy3), 32'(3'b100));
    v3 = 3'b011; d3 = 24'h00_2120;
    tick();
    b = 0;
    while (!start3 && b < 40) begin
      tick();
      b++;
    end
    check("n3_grant_b", 32'(gid3), 32'(0));
    check("n3_data_b", 32'(data3), 32'(8'h20));
    v3 = 3'b010;
    tick();
    b = 0;
    while (!start3 && b < 40) begin
      tick();
      b++;
    end
    check("n3_grant_c", 32'(gid3), 32'(1));
    check("n3_data_c", 32'(data3), 32'(8'h21));
    v3 = '0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
